// File: rtl/serial_cmd_processor_p_if.sv
// Byte-level handshake between the UART (master) and the serial command processor (slave).
interface serial_cmd_processor_p_if;
   logic       rxReady;
   logic [7:0] rxData;
   logic       txBusy;
   logic       txStart;
   logic [7:0] txData;

   modport master (output rxReady, output rxData, output txBusy,
                   input txStart, input txData);
   modport slave  (input rxReady, input rxData, input txBusy,
                   output txStart, output txData);
endinterface

// File: rtl/serial_cmd_processor_p.sv
// Serial command decoder: opcode plus arguments from the UART drive a config register file,
// PLL reconfiguration requests, or a frozen histogram snapshot streamed back over tx.
module serial_cmd_processor_p #(
   parameter int              NHIST      = 8,
   parameter int              HWIDTH     = 32,
   parameter int              NREG       = 8,
   parameter logic [NREG*8-1:0] REG_INIT = 64'h0000_0000_F00F_090A,
   parameter logic [7:0]      FW_VERSION = 8'd14,
   parameter int              TIMEOUT    = 1000000
) (
   input  logic                    clk,
   input  logic                    reset,
   serial_cmd_processor_p_if.slave uart,
   input  logic [NHIST*HWIDTH-1:0] h,
   output logic                    resethist,
   output logic [NREG*8-1:0]       regs,
   output logic                    enable_outputs,
   output logic                    pll_clk_src,
   output logic [7:0]              pll_clk_phase,
   output logic                    updatepll,
   output logic                    cmd_error
);

   localparam int NBYTES = NHIST * HWIDTH / 8;
   localparam int WBYTES = HWIDTH / 8;
   localparam int IDX_W  = $clog2(NBYTES + 1);
   localparam int TCNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARGS, S_EXEC, S_TXLOAD, S_TXHOLD, S_PLLUPD
   } state_t;

   state_t                  state;
   logic [7:0]              opcode;
   logic [7:0]              arg0;
   logic [7:0]              arg1;
   logic [1:0]              need;
   logic                    arg_idx;
   logic [TCNT_W-1:0]       tcnt;
   logic [NHIST*HWIDTH-1:0] tx_buf;
   logic [IDX_W-1:0]        idx;
   logic [IDX_W-1:0]        len;

   function automatic logic [1:0] arg_count(input logic [7:0] op);
      case (op)
         8'd1:                arg_count = 2'd2;
         8'd2, 8'd5, 8'd11:   arg_count = 2'd1;
         default:             arg_count = 2'd0;
      endcase
   endfunction

   // NOTE: every register here is assigned with <= so all reads within a cycle see the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      // NOTE: pulse outputs default low each cycle and are raised only where a state asks
      // for them, which is what makes them exactly one cycle wide.
      uart.txStart <= 1'b0;
      resethist    <= 1'b0;
      updatepll    <= 1'b0;
      cmd_error    <= 1'b0;

      if (reset) begin
         // NOTE: the register file is a handful of flops, not a RAM, so it takes a reset value.
         regs           <= REG_INIT;
         uart.txData    <= 8'd0;
         enable_outputs <= 1'b0;
         pll_clk_src    <= 1'b0;
         pll_clk_phase  <= 8'd0;
         state          <= S_IDLE;
         opcode         <= 8'd0;
         arg0           <= 8'd0;
         arg1           <= 8'd0;
         need           <= 2'd0;
         arg_idx        <= 1'b0;
         tcnt           <= '0;
         tx_buf         <= '0;
         idx            <= '0;
         len            <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (uart.rxReady) begin
                  opcode  <= uart.rxData;
                  need    <= arg_count(uart.rxData);
                  arg_idx <= 1'b0;
                  tcnt    <= '0;
                  state   <= (arg_count(uart.rxData) == 2'd0) ? S_EXEC : S_ARGS;
               end
            end

            S_ARGS: begin
               if (uart.rxReady) begin
                  if (!arg_idx) arg0 <= uart.rxData;
                  else          arg1 <= uart.rxData;
                  tcnt <= '0;
                  if ({1'b0, arg_idx} == need - 2'd1) state   <= S_EXEC;
                  else                                arg_idx <= 1'b1;
               end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                  cmd_error <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            S_EXEC: begin
               idx   <= '0;
               state <= S_IDLE;
               case (opcode)
                  8'd0: begin
                     tx_buf[7:0] <= FW_VERSION;
                     len         <= IDX_W'(1);
                     state       <= S_TXLOAD;
                  end
                  8'd1: begin
                     if (int'(arg0) < NREG) regs[int'(arg0)*8 +: 8] <= arg1;
                     else                   cmd_error <= 1'b1;
                  end
                  8'd2: begin
                     if (int'(arg0) < NREG) begin
                        tx_buf[7:0] <= regs[int'(arg0)*8 +: 8];
                        len         <= IDX_W'(1);
                        state       <= S_TXLOAD;
                     end else begin
                        cmd_error <= 1'b1;
                     end
                  end
                  8'd3: enable_outputs <= ~enable_outputs;
                  8'd4: begin
                     pll_clk_src <= ~pll_clk_src;
                     updatepll   <= 1'b1;
                     state       <= S_PLLUPD;
                  end
                  8'd5: begin
                     pll_clk_phase <= arg0;
                     updatepll     <= 1'b1;
                     state         <= S_PLLUPD;
                  end
                  8'd10: begin
                     tx_buf    <= h;
                     len       <= IDX_W'(NBYTES);
                     resethist <= 1'b1;
                     state     <= S_TXLOAD;
                  end
                  8'd11: begin
                     if (int'(arg0) < NHIST) begin
                        tx_buf[HWIDTH-1:0] <= h[int'(arg0)*HWIDTH +: HWIDTH];
                        len                <= IDX_W'(WBYTES);
                        state              <= S_TXLOAD;
                     end else begin
                        cmd_error <= 1'b1;
                     end
                  end
                  8'd13: begin
                     pll_clk_phase <= 8'd0;
                     pll_clk_src   <= 1'b0;
                     updatepll     <= 1'b1;
                     state         <= S_PLLUPD;
                  end
                  default: cmd_error <= 1'b1;
               endcase
            end

            // updatepll was raised on the way in; this state only spaces it from the next command
            S_PLLUPD: state <= S_IDLE;

            S_TXLOAD: begin
               if (!uart.txBusy) begin
                  uart.txData  <= tx_buf[int'(idx)*8 +: 8];
                  uart.txStart <= 1'b1;
                  state        <= S_TXHOLD;
               end
            end

            S_TXHOLD: begin
               if (int'(idx) + 1 < int'(len)) begin
                  idx   <= idx + 1'b1;
                  state <= S_TXLOAD;
               end else begin
                  state <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_cmd_processor_p.sv
// Directed bench: a command-level model predicts tx bytes, pulse counts and register state;
// a negedge compare process checks the DUT against it, plus literal spot checks.
module tb_serial_cmd_processor_p;
   localparam int          NHIST    = 8;
   localparam int          HWIDTH   = 32;
   localparam int          NREG     = 8;
   localparam int          TIMEOUT  = 200;
   localparam logic [63:0] REG_INIT = 64'h0000_0000_F00F_090A;
   localparam logic [7:0]  FW       = 8'd14;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic [NHIST*HWIDTH-1:0] h;
   logic                    resethist;
   logic [NREG*8-1:0]       regs;
   logic                    enable_outputs;
   logic                    pll_clk_src;
   logic [7:0]              pll_clk_phase;
   logic                    updatepll;
   logic                    cmd_error;

   serial_cmd_processor_p_if uif();

   serial_cmd_processor_p #(
      .NHIST(NHIST), .HWIDTH(HWIDTH), .NREG(NREG), .REG_INIT(REG_INIT),
      .FW_VERSION(FW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .uart(uif), .h(h), .resethist(resethist), .regs(regs),
      .enable_outputs(enable_outputs), .pll_clk_src(pll_clk_src),
      .pll_clk_phase(pll_clk_phase), .updatepll(updatepll), .cmd_error(cmd_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]        exp_q[$];
   logic [7:0]        log_q[$];
   logic [NREG*8-1:0] m_regs = REG_INIT;
   logic              m_en = 1'b0;
   logic              m_src = 1'b0;
   logic [7:0]        m_phase = 8'd0;
   int exp_err = 0, exp_upd = 0, exp_rh = 0;
   int n_err = 0, n_upd = 0, n_rh = 0;
   logic check_req = 1'b0;

   logic force_busy = 1'b0;
   logic busy_at_edge = 1'b0;
   int   busy_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // UART tx side: busy for a few cycles after each txStart, or held by the stimulus
   always @(posedge clk) begin
      #2;
      busy_at_edge = uif.txBusy;
      if (uif.txStart === 1'b1) busy_cnt = 3;
      else if (busy_cnt > 0)    busy_cnt--;
      uif.txBusy = force_busy || (busy_cnt > 0);
   end

   always @(negedge clk) begin
      if (uif.txStart === 1'b1) begin
         log_q.push_back(uif.txData);
         check("tx_while_busy", busy_at_edge, 0);
         if (exp_q.size() == 0) check("tx_unexpected", uif.txStart, 0);
         else                   check("tx_byte", uif.txData, exp_q.pop_front());
      end
      if (cmd_error === 1'b1) n_err++;
      if (updatepll === 1'b1) n_upd++;
      if (resethist === 1'b1) n_rh++;
      if (check_req) begin
         check("regs", regs, m_regs);
         check("enable_outputs", enable_outputs, m_en);
         check("pll_clk_src", pll_clk_src, m_src);
         check("pll_clk_phase", pll_clk_phase, m_phase);
         check_req = 1'b0;
      end
   end

   // Command semantics at transaction level, evaluated with h as it is when the command is sent
   task automatic model_cmd(input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1);
      case (op)
         8'd0: exp_q.push_back(FW);
         8'd1: if (a0 < NREG) m_regs[a0*8 +: 8] = a1; else exp_err++;
         8'd2: if (a0 < NREG) exp_q.push_back(m_regs[a0*8 +: 8]); else exp_err++;
         8'd3: m_en = ~m_en;
         8'd4: begin m_src = ~m_src; exp_upd++; end
         8'd5: begin m_phase = a0; exp_upd++; end
         8'd10: begin
            exp_rh++;
            for (int c = 0; c < NHIST; c++)
               for (int b = 0; b < HWIDTH/8; b++) exp_q.push_back(h[c*HWIDTH + b*8 +: 8]);
         end
         8'd11: begin
            if (a0 < NHIST)
               for (int b = 0; b < HWIDTH/8; b++) exp_q.push_back(h[a0*HWIDTH + b*8 +: 8]);
            else exp_err++;
         end
         8'd13: begin m_phase = 8'd0; m_src = 1'b0; exp_upd++; end
         default: exp_err++;
      endcase
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_regs = REG_INIT; m_en = 1'b0; m_src = 1'b0; m_phase = 8'd0;
   endtask

   task automatic rx_byte(input logic [7:0] b);
      @(negedge clk);
      uif.rxData = b; uif.rxReady = 1'b1;
      @(negedge clk);
      uif.rxReady = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      int quiet = 0;
      while (quiet < 8 && n < 3000) begin
         @(negedge clk);
         n++;
         if (exp_q.size() == 0 && uif.txStart !== 1'b1) quiet++;
         else quiet = 0;
      end
      check("idle_reached", exp_q.size(), 0);
   endtask

   task automatic finish_cmd();
      wait_idle();
      check("cmd_error_pulses", n_err, exp_err);
      check("updatepll_pulses", n_upd, exp_upd);
      check("resethist_pulses", n_rh, exp_rh);
      check_req = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic cmd0(input logic [7:0] op);
      model_cmd(op, 8'd0, 8'd0); rx_byte(op); finish_cmd();
   endtask
   task automatic cmd1(input logic [7:0] op, input logic [7:0] a0);
      model_cmd(op, a0, 8'd0); rx_byte(op); rx_byte(a0); finish_cmd();
   endtask
   task automatic cmd2(input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1);
      model_cmd(op, a0, a1); rx_byte(op); rx_byte(a0); rx_byte(a1); finish_cmd();
   endtask

   task automatic wait_log(input int target);
      int n = 0;
      while (log_q.size() < target && n < 2000) begin @(negedge clk); n++; end
      check("log_progress", log_q.size() >= target, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      uif.rxReady = 1'b0; uif.rxData = 8'd0; uif.txBusy = 1'b0;
      for (int c = 0; c < NHIST; c++) h[c*HWIDTH +: HWIDTH] = 32'h1111_1111 * (c + 1);
      h[0 +: 32]   = 32'h0403_0201;
      h[224 +: 32] = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // reset state
      check("rst_txStart", uif.txStart, 0);
      check("rst_txData", uif.txData, 0);
      check("rst_regs", regs, 64'h0000_0000_F00F_090A);
      check("rst_enable", enable_outputs, 0);
      check("rst_cmd_error", cmd_error, 0);
      check("rst_updatepll", updatepll, 0);

      // firmware version
      base = log_q.size();
      cmd0(8'h00);
      check("fw_count", log_q.size(), base + 1);
      check("fw_byte", log_q[log_q.size()-1], 8'd14);

      // register write / read / out-of-range
      cmd2(8'h01, 8'h03, 8'hAA);
      check("reg3_lit", regs[31:24], 8'hAA);
      cmd1(8'h02, 8'h03);
      check("reg3_read", log_q[log_q.size()-1], 8'hAA);
      cmd2(8'h01, 8'h09, 8'h55);
      cmd1(8'h02, 8'h08);
      cmd1(8'h0B, 8'h08);
      cmd0(8'h03);

      // full histogram dump with h changing mid-stream
      base = log_q.size();
      model_cmd(8'h0A, 8'd0, 8'd0);
      rx_byte(8'h0A);
      wait_log(base + 5);
      h[0 +: 32]   = 32'hCAFE_F00D;
      h[224 +: 32] = 32'h1234_5678;
      finish_cmd();
      check("h_count", log_q.size(), base + 32);
      check("h_first", {log_q[base+3], log_q[base+2], log_q[base+1], log_q[base]}, 32'h0403_0201);
      check("h_last", {log_q[base+31], log_q[base+30], log_q[base+29], log_q[base+28]}, 32'hDEAD_BEEF);

      // single channel while tx is held busy
      h[224 +: 32] = 32'hDEAD_BEEF;
      @(negedge clk);
      force_busy = 1'b1;
      base = log_q.size();
      model_cmd(8'h0B, 8'h07, 8'd0);
      rx_byte(8'h0B); rx_byte(8'h07);
      repeat (500) @(negedge clk);
      check("busy_no_tx", log_q.size(), base);
      force_busy = 1'b0;
      finish_cmd();
      check("ch7_count", log_q.size(), base + 4);
      check("ch7_bytes", {log_q[base], log_q[base+1], log_q[base+2], log_q[base+3]}, 32'hEFBE_ADDE);

      // PLL controls
      cmd1(8'h05, 8'h2C);
      check("phase_lit", pll_clk_phase, 8'h2C);
      cmd0(8'h04);
      cmd0(8'h0D);
      check("phase_zero", pll_clk_phase, 8'h00);
      check("src_zero", pll_clk_src, 1'b0);

      // argument timeout, then bad opcode, then machine still responds
      exp_err++;
      rx_byte(8'h01);
      repeat (TIMEOUT - 20) @(negedge clk);
      check("no_early_timeout", n_err, exp_err - 1);
      repeat (40) @(negedge clk);
      check("timeout_err", n_err, exp_err);
      finish_cmd();
      cmd0(8'h77);
      cmd0(8'h03);

      // reset in the middle of a histogram dump
      base = log_q.size();
      model_cmd(8'h0A, 8'd0, 8'd0);
      rx_byte(8'h0A);
      wait_log(base + 3);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      base = log_q.size();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      check("no_tx_after_reset", log_q.size(), base);
      finish_cmd();
      cmd0(8'h00);
      check("fw_after_reset", log_q[log_q.size()-1], 8'd14);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
